// File: rtl/sdram_test_seq.sv
// sdram_test_seq - SDRAM pattern tester.
// Waits for controller init, writes a selectable pattern to NUM_WORDS
// consecutive word addresses, reads them back and compares. Reports
// pass/fail, a saturating mismatch count and the first failing address.
// Optional build macro SDRAM_SEQ_TIMEOUT_EN adds a cmd_done watchdog that
// aborts the pass after TIMEOUT wait cycles; without it timeout is tied low.
module sdram_test_seq #(
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 16,
  parameter int                NUM_WORDS  = 256,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              init_comp,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_done,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_INIT = 3'd1;
  localparam logic [2:0] S_WR_REQ    = 3'd2;
  localparam logic [2:0] S_WR_WAIT   = 3'd3;
  localparam logic [2:0] S_RD_REQ    = 3'd4;
  localparam logic [2:0] S_RD_WAIT   = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_READ  = 4'd2;

  localparam logic [15:0]       LFSR_SEED = 16'hACE1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);
  localparam int                REP       = DATA_W / 16 + 1;

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] index;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;
  logic [DATA_W-1:0] exp_data;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] walk_pos;
  logic [DATA_W-1:0] pattern;
  logic              waiting;
  logic              wd_expired;

  assign cur_addr  = START_ADDR + index;
  assign walk_pos  = index % ADDR_W'(DATA_W);
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign waiting   = (state == S_WR_WAIT) || (state == S_RD_WAIT);
  assign pass      = done && (err_count == 16'd0) && !timeout;

  // Data word for the current index; reads regenerate the same sequence
  always_comb begin
    pattern = '0;
    case (mode_q)
      2'd0:    pattern = DATA_W'(index);
      2'd1:    pattern = DATA_W'(1) << walk_pos;
      2'd2:    pattern = DATA_W'({REP{lfsr}});
      default: pattern = DATA_W'(cur_addr);
    endcase
  end

`ifdef SDRAM_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  assign wd_expired = waiting && !cmd_done && (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout    = timeout_q;

  // Watchdog: counts cycles spent waiting for cmd_done, restarts per command
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (waiting && !cmd_done) wd_cnt <= wd_cnt + CNT_W'(1);
      else                      wd_cnt <= '0;
      if (((state == S_IDLE) || (state == S_DONE)) && start) timeout_q <= 1'b0;
      else if (wd_expired)                                   timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Main sequencer: write phase, read/compare phase, result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= 2'd0;
      cmd       <= CMD_NOP;
      cmd_valid <= 1'b0;
      cmd_addr  <= START_ADDR;
      cmd_wdata <= '0;
      exp_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= 16'd0;
      fail_addr <= '0;
      index     <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q    <= mode;
            err_count <= 16'd0;
            fail_addr <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            index     <= '0;
            lfsr      <= LFSR_SEED;
            state     <= S_WAIT_INIT;
          end
        end
        S_WAIT_INIT: begin
          if (init_comp) state <= S_WR_REQ;
        end
        S_WR_REQ: begin
          cmd       <= CMD_WRITE;
          cmd_valid <= 1'b1;
          cmd_addr  <= cur_addr;
          cmd_wdata <= pattern;
          state     <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (cmd_done) begin
            cmd       <= CMD_NOP;
            cmd_valid <= 1'b0;
            if (index == LAST_IDX) begin
              index <= '0;
              lfsr  <= LFSR_SEED;
              state <= S_RD_REQ;
            end else begin
              index <= index + ADDR_W'(1);
              lfsr  <= lfsr_next;
              state <= S_WR_REQ;
            end
          end else if (wd_expired) begin
            cmd       <= CMD_NOP;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_RD_REQ: begin
          cmd       <= CMD_READ;
          cmd_valid <= 1'b1;
          cmd_addr  <= cur_addr;
          cmd_wdata <= '0;
          exp_data  <= pattern;
          state     <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (cmd_done) begin
            cmd       <= CMD_NOP;
            cmd_valid <= 1'b0;
            lfsr      <= lfsr_next;
            if (rd_data != exp_data) begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              if (err_count == 16'd0)    fail_addr <= cmd_addr;
            end
            if (index == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              index <= index + ADDR_W'(1);
              state <= S_RD_REQ;
            end
          end else if (wd_expired) begin
            cmd       <= CMD_NOP;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_test_seq.sv
// tb_sdram_test_seq - scoreboard bench for sdram_test_seq.
// A responder models the SDRAM controller with a memory and random latency;
// expected commands and pass results come from a reference model of the
// pattern rules and are checked by an independent monitor.
module tb_sdram_test_seq;

  localparam int          ADDR_W     = 24;
  localparam int          DATA_W     = 16;
  localparam int          NUM_WORDS  = 8;
  localparam logic [23:0] START_ADDR = 24'hFFFFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        init_comp;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_done;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [23:0] fail_addr;
  logic        timeout;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [23:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct packed {
    logic [15:0] errs;
    logic [23:0] faddr;
    logic        pass;
  } res_t;

  cmd_t        exp_cmd_q[$];
  res_t        exp_res_q[$];
  bit          corrupt[logic [23:0]];
  logic [15:0] mem[logic [23:0]];

  sdram_test_seq #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .START_ADDR(START_ADDR),
    .TIMEOUT   (4096)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .init_comp(init_comp),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_done (cmd_done),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference pattern for word i, straight from the pattern definitions
  function automatic logic [15:0] modelWord(input logic [1:0] m, input int i);
    logic [15:0] v;
    logic [23:0] a;
    case (m)
      2'd0: return 16'(i);
      2'd1: return 16'(1) << (i % 16);
      2'd2: begin
        v = 16'hACE1;
        for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return v;
      end
      default: begin
        a = START_ADDR + 24'(i);
        return a[15:0];
      end
    endcase
  endfunction

  // Push the expected command stream and result, then pulse start
  task automatic applyStimulus(input logic [1:0] m, input int init_delay, input bit drop_init);
    int          errs;
    logic [23:0] fa;
    logic [23:0] a;
    bit          seen;
    errs = 0; fa = '0; seen = 0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      a = START_ADDR + 24'(i);
      exp_cmd_q.push_back('{cmd: 4'd1, addr: a, data: modelWord(m, i)});
    end
    for (int i = 0; i < NUM_WORDS; i++) begin
      a = START_ADDR + 24'(i);
      exp_cmd_q.push_back('{cmd: 4'd2, addr: a, data: 16'h0});
      if (corrupt.exists(a)) begin
        errs++;
        if (!seen) begin fa = a; seen = 1; end
      end
    end
    exp_res_q.push_back('{errs: 16'(errs), faddr: fa, pass: (errs == 0)});
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 2'($urandom);
    if (init_delay > 0) begin
      repeat (init_delay) @(negedge clk);
      checkOutput("wait_init_busy", {31'd0, busy}, 32'd1);
      checkOutput("wait_init_no_cmd", {31'd0, cmd_valid}, 32'd0);
      init_comp = 1'b1;
    end
    if (drop_init) begin
      for (int c = 0; c < 50 && !cmd_valid; c++) @(negedge clk);
      init_comp = 1'b0;
    end
  endtask

  task automatic waitDone(input int budget);
    for (int c = 0; c < budget && !done; c++) @(negedge clk);
    checkOutput("pass_completes", {31'd0, done}, 32'd1);
    init_comp = 1'b1;
  endtask

  // Controller model: random latency, memory echo, optional read corruption
  initial begin
    int wait_cnt;
    bit pending;
    pending = 0; wait_cnt = 0;
    cmd_done = 1'b0; rd_data = '0;
    forever begin
      @(posedge clk); #1;
      cmd_done = 1'b0;
      rd_data  = 16'($urandom);
      if (!cmd_valid) begin
        pending = 0;
        if (busy && $urandom_range(0, 9) == 0) cmd_done = 1'b1;
      end else begin
        if (!pending) begin
          pending  = 1;
          wait_cnt = $urandom_range(0, 3);
        end
        if (wait_cnt == 0) begin
          cmd_done = 1'b1;
          if (cmd == 4'd1) mem[cmd_addr] = cmd_wdata;
          else if (cmd == 4'd2)
            rd_data = (mem.exists(cmd_addr) ? mem[cmd_addr] : 16'h0) ^
                      (corrupt.exists(cmd_addr) ? 16'h1 : 16'h0);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: checks each new command and each pass result against the queues
  initial begin
    logic        prev_valid, prev_done;
    logic [3:0]  cap_cmd;
    logic [23:0] cap_addr;
    logic [15:0] cap_wdata;
    cmd_t        e;
    res_t        r;
    prev_valid = 1'b0; prev_done = 1'b0;
    cap_cmd = '0; cap_addr = '0; cap_wdata = '0;
    forever begin
      @(negedge clk);
      if (cmd_valid && !prev_valid) begin
        if (exp_cmd_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_cmd: got cmd %0h addr %0h, expected none", cmd, cmd_addr);
        end else begin
          e = exp_cmd_q.pop_front();
          checkOutput("cmd", {28'd0, cmd}, {28'd0, e.cmd});
          checkOutput("cmd_addr", {8'd0, cmd_addr}, {8'd0, e.addr});
          if (e.cmd == 4'd1) checkOutput("cmd_wdata", {16'd0, cmd_wdata}, {16'd0, e.data});
          checkOutput("busy_during_cmd", {31'd0, busy}, 32'd1);
        end
        cap_cmd = cmd; cap_addr = cmd_addr; cap_wdata = cmd_wdata;
      end else if (cmd_valid) begin
        n_checks++;
        if (cmd === cap_cmd && cmd_addr === cap_addr && cmd_wdata === cap_wdata) n_pass++;
        else $display("[TB] FAIL cmd_stable: got %0h/%0h/%0h, expected %0h/%0h/%0h",
                      cmd, cmd_addr, cmd_wdata, cap_cmd, cap_addr, cap_wdata);
      end
      if (done && !prev_done) begin
        if (exp_res_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_done: got done 1, expected no result");
        end else begin
          r = exp_res_q.pop_front();
          checkOutput("err_count", {16'd0, err_count}, {16'd0, r.errs});
          checkOutput("fail_addr", {8'd0, fail_addr}, {8'd0, r.faddr});
          checkOutput("pass", {31'd0, pass}, {31'd0, r.pass});
          checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
          checkOutput("timeout", {31'd0, timeout}, 32'd0);
          checkOutput("valid_at_done", {31'd0, cmd_valid}, 32'd0);
        end
      end
      prev_valid = cmd_valid;
      prev_done  = done;
    end
  end

  // Stimulus sequence
  initial begin
    int got;
    rst = 1'b1; start = 1'b0; mode = 2'd0; init_comp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    checkOutput("rst_cmd", {28'd0, cmd}, 32'd0);
    checkOutput("rst_cmd_addr", {8'd0, cmd_addr}, {8'd0, START_ADDR});
    checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("rst_err_fail", {err_count, fail_addr[15:0]}, 32'd0);
    checkOutput("rst_pass_timeout", {30'd0, pass, timeout}, 32'd0);
    rst = 1'b0;

    $display("[TB] pass 1: incrementing, init delayed");
    corrupt.delete();
    applyStimulus(2'd0, 6, 0);
    waitDone(1000);

    $display("[TB] pass 2: LFSR");
    applyStimulus(2'd2, 0, 0);
    waitDone(1000);

    $display("[TB] pass 3: walking ones, corrupted reads");
    corrupt.delete();
    corrupt[START_ADDR + 24'd5] = 1;
    corrupt[START_ADDR + 24'd6] = 1;
    applyStimulus(2'd1, 0, 1);
    waitDone(1000);

    $display("[TB] pass 4: address as data across wrap");
    corrupt.delete();
    applyStimulus(2'd3, 0, 0);
    waitDone(1000);

    $display("[TB] reset during read wait");
    corrupt[START_ADDR] = 1;
    applyStimulus(2'd0, 0, 0);
    got = 0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      if (cmd_valid && cmd == 4'd2 && cmd_addr == 24'hFFFFFF) got = 1;
    end
    checkOutput("reached_rd_wait", got, 32'd1);
    checkOutput("err_before_rst", {16'd0, err_count}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cmd_q.delete();
    exp_res_q.delete();
    checkOutput("midrst_valid", {31'd0, cmd_valid}, 32'd0);
    checkOutput("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("midrst_err", {16'd0, err_count}, 32'd0);
    checkOutput("midrst_addr", {8'd0, cmd_addr}, {8'd0, START_ADDR});
    corrupt.delete();
    applyStimulus(2'd3, 0, 0);
    waitDone(1000);

    $display("[TB] random passes");
    for (int p = 0; p < 5; p++) begin
      corrupt.delete();
      for (int i = 0; i < NUM_WORDS; i++)
        if ($urandom_range(0, 3) == 0) corrupt[START_ADDR + 24'(i)] = 1;
      applyStimulus(2'($urandom_range(0, 3)), 0, 1'($urandom_range(0, 1)));
      waitDone(1000);
    end

    repeat (5) @(negedge clk);
    checkOutput("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
    checkOutput("res_queue_drained", exp_res_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
